// File: rtl/fifo_gen_pkg.sv
// Shared types and constants for the FIFO push generator: FSM states, data
// modes, the alternating-word constant and the Galois LFSR tap table.
package fifo_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_INC  = 2'd0,
    MODE_LFSR = 2'd1,
    MODE_ALT  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_t;

  // {...0101} with bit 0 set; its complement is the other alternating word.
  function automatic logic [31:0] alt_pattern(input int width);
    logic [31:0] p;
    p = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width && (i % 2) == 0) p[i] = 1'b1;
    end
    return p;
  endfunction

  // Right-shift Galois masks of maximal-length polynomials.
  function automatic logic [31:0] lfsr_taps(input int width);
    logic [31:0] t;
    case (width)
      2:       t = 32'h0000_0003;
      3:       t = 32'h0000_0006;
      4:       t = 32'h0000_000C;
      5:       t = 32'h0000_0014;
      6:       t = 32'h0000_0030;
      7:       t = 32'h0000_0060;
      8:       t = 32'h0000_00B8;
      9:       t = 32'h0000_0110;
      10:      t = 32'h0000_0240;
      11:      t = 32'h0000_0500;
      12:      t = 32'h0000_0E08;
      13:      t = 32'h0000_1C80;
      14:      t = 32'h0000_3802;
      15:      t = 32'h0000_6000;
      16:      t = 32'h0000_B400;
      default: t = 32'h0000_0030;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/fifo_push_gen_if.sv
// Producer-to-FIFO bus: write strobe and data downstream, pop strobe observed
// back from the FIFO read side.
interface fifo_push_gen_if #(
  parameter int D_WIDTH = 6
);
  logic               push;
  logic [D_WIDTH-1:0] up_data;
  logic               pop;

  modport master (output push, output up_data, input pop);
  modport slave  (input push, input up_data, output pop);
endinterface

// File: rtl/fifo_push_gen_lfsr_gen.sv
// Galois LFSR word source; reloads the seed on load, steps on advance.
module lfsr_gen
  import fifo_gen_pkg::*;
#(
  parameter int               WIDTH = 6,
  parameter logic [WIDTH-1:0] SEED  = 6'h2D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

  logic [WIDTH-1:0] q_next;

  assign q_next = {1'b0, q[WIDTH-1:1]} ^ (q[0] ? TAPS : '0);

  always_ff @(posedge clk) begin
    if (rst || load) q <= SEED;
    else if (advance) q <= q_next;
  end

endmodule

// File: rtl/fifo_push_gen.sv
// Upstream FIFO traffic generator: pushes a latched number of pattern words,
// never exceeding DEPTH, using a local mirror of the FIFO fill level.
module fifo_push_gen
  import fifo_gen_pkg::*;
#(
  parameter int                 D_WIDTH   = 6,
  parameter int                 DEPTH     = 4,
  parameter logic [D_WIDTH-1:0] LFSR_SEED = 6'h2D,
  localparam int                OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [7:0]         length,
  input  logic [3:0]         gap,
  fifo_push_gen_if.master    bus,
  output logic               busy,
  output logic               done,
  output logic [OCC_W-1:0]   occupancy,
  output logic [15:0]        stall_cnt,
  output state_t             state_dbg
);

  localparam logic [D_WIDTH-1:0] ALT_WORD = D_WIDTH'(alt_pattern(D_WIDTH));

  state_t             state;
  mode_t              mode_q;
  logic [7:0]         len_q;
  logic [7:0]         sent;
  logic [3:0]         gap_q;
  logic [3:0]         gap_cnt;
  logic [D_WIDTH-1:0] data_q;
  logic [D_WIDTH-1:0] lfsr_q;
  logic               push;
  logic               start_ok;
  logic               pop_eff;

  // A pop seen this cycle cannot make room for this cycle's push.
  assign push      = (state == ST_SEND) && (occupancy < OCC_W'(DEPTH));
  assign start_ok  = (state == ST_IDLE) && start;
  assign pop_eff   = bus.pop && ((occupancy != '0) || push);

  assign bus.push    = push;
  assign bus.up_data = (mode_q == MODE_LFSR) ? lfsr_q : data_q;
  assign state_dbg   = state;

  lfsr_gen #(
    .WIDTH (D_WIDTH),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (start_ok),
    .advance (push && (mode_q == MODE_LFSR)),
    .q       (lfsr_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      mode_q  <= MODE_INC;
      len_q   <= '0;
      sent    <= '0;
      gap_q   <= '0;
      gap_cnt <= '0;
      data_q  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q <= mode_t'(mode);
            len_q  <= length;
            gap_q  <= gap;
            sent   <= '0;
            data_q <= (mode_t'(mode) == MODE_ALT) ? ALT_WORD : '0;
            if (length == 8'd0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_SEND;
              busy  <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (push) begin
            sent   <= sent + 8'd1;
            data_q <= (mode_q == MODE_ALT) ? ~data_q : data_q + 1'b1;
            if (sent + 8'd1 == len_q) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (gap_q != 4'd0) begin
              state   <= ST_GAP;
              gap_cnt <= gap_q - 4'd1;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == 4'd0) state <= ST_SEND;
          else gap_cnt <= gap_cnt - 4'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy <= '0;
      stall_cnt <= '0;
    end else begin
      occupancy <= occupancy + OCC_W'(push) - OCC_W'(pop_eff);
      if ((state == ST_SEND) && !push && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_push_gen.sv
// Directed bench for fifo_push_gen: per-cycle vector table plus LFSR
// uniqueness/replay sequence.
module tb_fifo_push_gen;
  import fifo_gen_pkg::*;

  localparam int D_WIDTH = 6;
  localparam int DEPTH   = 4;
  localparam logic [D_WIDTH-1:0] SEED = 6'h2D;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [7:0]  length;
  logic [3:0]  gap;
  logic        busy;
  logic        done;
  logic [2:0]  occupancy;
  logic [15:0] stall_cnt;
  state_t      state_dbg;

  fifo_push_gen_if #(.D_WIDTH(D_WIDTH)) bus ();

  fifo_push_gen #(
    .D_WIDTH   (D_WIDTH),
    .DEPTH     (DEPTH),
    .LFSR_SEED (SEED)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .length    (length),
    .gap       (gap),
    .bus       (bus.master),
    .busy      (busy),
    .done      (done),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [7:0]  len;
    logic [3:0]  gap;
    logic        pop;
    logic        push;
    logic [5:0]  data;
    logic        busy;
    logic        done;
    logic [2:0]  occ;
    logic [15:0] stall;
  } vec_t;

  vec_t vecs[$];
  logic [D_WIDTH-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic vec_t mk(int r, int s, int m, int l, int g, int p,
                              int e_push, int e_data, int e_busy, int e_done,
                              int e_occ, int e_stall);
    vec_t v;
    v.rst = r[0]; v.start = s[0]; v.mode = m[1:0]; v.len = l[7:0];
    v.gap = g[3:0]; v.pop = p[0];
    v.push = e_push[0]; v.data = e_data[5:0]; v.busy = e_busy[0];
    v.done = e_done[0]; v.occ = e_occ[2:0]; v.stall = e_stall[15:0];
    return v;
  endfunction

  task automatic check(input string name, input int unsigned got,
                       input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [1:0] m, input logic [7:0] l,
                       input logic [3:0] g, input logic p);
    start = s; mode = m; length = l; gap = g; bus.pop = p;
  endtask

  // Collect one LFSR transfer; returns the cycle (after start) done fired on.
  task automatic lfsr_run(input bit record, output int n_words, output int done_at);
    logic [D_WIDTH-1:0] w;
    bit got_done;
    n_words = 0; done_at = -1; got_done = 0;
    drive(1'b1, 2'd1, 8'd63, 4'd0, 1'b1);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 100 && !got_done; c++) begin
      if (bus.push === 1'b1) begin
        w = bus.up_data;
        n_words++;
        if (record) begin
          exp_q.push_back(w);
        end else if (exp_q.size() == 0) begin
          check("lfsr_replay_extra", 32'(w), 32'hFFFF_FFFF);
        end else begin
          check("lfsr_replay_word", 32'(w), 32'(exp_q.pop_front()));
        end
      end
      if (done === 1'b1) begin
        got_done = 1;
        done_at  = c;
      end
      tick();
    end
    if (!got_done) check("lfsr_done_timeout", 0, 1);
  endtask

  initial begin
    int n_words;
    int done_at;
    bit seen[64];

    rst = 1'b1;
    drive(1'b0, 2'd0, 8'd0, 4'd0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    // Increment, length 3, pop held: pop on empty cancels each push.
    vecs.push_back(mk(0,1,0,3,0,1, 0,'h00,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,1, 1,'h00,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,1, 1,'h01,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,1, 1,'h02,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,'h03,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,1, 0,'h03,0,0,0,0));
    // Increment, length 6, fills to DEPTH and stalls; single pops release it.
    vecs.push_back(mk(0,1,0,6,0,0, 0,'h03,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,'h00,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,'h01,1,0,1,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,'h02,1,0,2,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,'h03,1,0,3,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,'h04,1,0,4,0));
    vecs.push_back(mk(0,0,0,0,0,1, 0,'h04,1,0,4,1));
    vecs.push_back(mk(0,0,0,0,0,0, 1,'h04,1,0,3,2));
    vecs.push_back(mk(0,0,0,0,0,1, 0,'h05,1,0,4,2));
    vecs.push_back(mk(0,0,0,0,0,0, 1,'h05,1,0,3,3));
    vecs.push_back(mk(0,0,0,0,0,1, 0,'h06,0,1,4,3));
    vecs.push_back(mk(0,0,0,0,0,1, 0,'h06,0,0,3,3));
    vecs.push_back(mk(0,0,0,0,0,1, 0,'h06,0,0,2,3));
    vecs.push_back(mk(0,0,0,0,0,1, 0,'h06,0,0,1,3));
    // Alternating, length 4, gap 2.
    vecs.push_back(mk(0,1,2,4,2,1, 0,'h06,0,0,0,3));
    vecs.push_back(mk(0,0,0,0,0,1, 1,'h15,1,0,0,3));
    vecs.push_back(mk(0,0,0,0,0,1, 0,'h2A,1,0,0,3));
    vecs.push_back(mk(0,0,0,0,0,1, 0,'h2A,1,0,0,3));
    vecs.push_back(mk(0,0,0,0,0,1, 1,'h2A,1,0,0,3));
    vecs.push_back(mk(0,0,0,0,0,1, 0,'h15,1,0,0,3));
    vecs.push_back(mk(0,0,0,0,0,1, 0,'h15,1,0,0,3));
    vecs.push_back(mk(0,0,0,0,0,1, 1,'h15,1,0,0,3));
    vecs.push_back(mk(0,0,0,0,0,1, 0,'h2A,1,0,0,3));
    vecs.push_back(mk(0,0,0,0,0,1, 0,'h2A,1,0,0,3));
    vecs.push_back(mk(0,0,0,0,0,1, 1,'h2A,1,0,0,3));
    vecs.push_back(mk(0,0,0,0,0,1, 0,'h15,0,1,0,3));
    // Length 0, then a start while busy that must be ignored.
    vecs.push_back(mk(0,1,0,0,0,0, 0,'h15,0,0,0,3));
    vecs.push_back(mk(0,0,0,0,0,0, 0,'h00,0,1,0,3));
    vecs.push_back(mk(0,1,0,2,0,1, 0,'h00,0,0,0,3));
    vecs.push_back(mk(0,1,2,9,3,1, 1,'h00,1,0,0,3));
    vecs.push_back(mk(0,0,0,0,0,1, 1,'h01,1,0,0,3));
    vecs.push_back(mk(0,0,0,0,0,1, 0,'h02,0,1,0,3));
    // Reset mid-SEND with occupancy 2.
    vecs.push_back(mk(0,1,0,6,0,0, 0,'h02,0,0,0,3));
    vecs.push_back(mk(0,0,0,0,0,0, 1,'h00,1,0,0,3));
    vecs.push_back(mk(0,0,0,0,0,0, 1,'h01,1,0,1,3));
    vecs.push_back(mk(1,0,0,0,0,0, 1,'h02,1,0,2,3));
    vecs.push_back(mk(0,0,0,0,0,0, 0,'h00,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,'h00,0,0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      drive(vecs[i].start, vecs[i].mode, vecs[i].len, vecs[i].gap, vecs[i].pop);
      check($sformatf("v%0d_push", i),  32'(bus.push),    32'(vecs[i].push));
      check($sformatf("v%0d_data", i),  32'(bus.up_data), 32'(vecs[i].data));
      check($sformatf("v%0d_busy", i),  32'(busy),        32'(vecs[i].busy));
      check($sformatf("v%0d_done", i),  32'(done),        32'(vecs[i].done));
      check($sformatf("v%0d_occ", i),   32'(occupancy),   32'(vecs[i].occ));
      check($sformatf("v%0d_stall", i), 32'(stall_cnt),   32'(vecs[i].stall));
      tick();
    end
    rst = 1'b0;
    check("post_rst_state", 32'(state_dbg), 32'(ST_IDLE));

    // LFSR, length 63: all words distinct and nonzero, then exact replay.
    lfsr_run(1'b1, n_words, done_at);
    check("lfsr_count", 32'(n_words), 32'd63);
    check("lfsr_done_cycle", 32'(done_at), 32'd64);
    check("lfsr_first_word", 32'((exp_q.size() > 0) ? exp_q[0] : '0), 32'(SEED));
    for (int i = 0; i < 64; i++) seen[i] = 1'b0;
    foreach (exp_q[i]) begin
      check($sformatf("lfsr_nonzero_%0d", i), 32'(exp_q[i] != '0), 32'd1);
      check($sformatf("lfsr_unique_%0d", i), 32'(seen[exp_q[i]]), 32'd0);
      seen[exp_q[i]] = 1'b1;
    end
    lfsr_run(1'b0, n_words, done_at);
    check("lfsr_replay_count", 32'(n_words), 32'd63);
    check("lfsr_replay_left", 32'(exp_q.size()), 32'd0);
    check("lfsr_end_occ", 32'(occupancy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_push_gen.md
# fifo_push_gen

Producer-side driver for the team's push/pop FIFO interface: generates `push`/`up_data` traffic for a FIFO of known depth and never overflows it. It tracks occupancy by mirroring its own pushes against the consumer's `pop` strobes. It sits on the upstream side of the FIFO in scenario benches and on-chip self-test paths, feeding the same `push`/`up_data` pins the FIFO and its queue model consume.

## Interface
- `D_WIDTH`, 6: data word width.
- `DEPTH`, 4: FIFO capacity in words; occupancy ceiling.
- `LFSR_SEED`, 6'h2D: nonzero reset/start value of the pseudo-random generator (width `D_WIDTH`).
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: begin a transfer; sampled only in IDLE.
- `mode` in 2: data pattern, latched at start. 0 = increment, 1 = LFSR, 2 = alternating, 3 = treated as 0.
- `length` in 8: number of words to push, latched at start.
- `gap` in 4: idle cycles inserted after each push, latched at start.
- `pop` in 1: consumer pop strobe, observed from the FIFO read side.
- `push` out 1: write strobe to FIFO.
- `up_data` out `D_WIDTH`: write data, valid when `push`=1.
- `busy` out 1: high in SEND and GAP.
- `done` out 1: one-cycle pulse at transfer completion.
- `occupancy` out `$clog2(DEPTH+1)`: mirrored FIFO fill level.
- `stall_cnt` out 16: SEND cycles blocked by full FIFO, saturating.

## Operation
- FSM states: IDLE, SEND, GAP, DONE.
- IDLE → SEND on `start`; IDLE → DONE on `start` with `length`=0.
- SEND → GAP after a push when latched `gap`>0 and words remain.
- SEND → DONE after the push that makes `sent`==`length`.
- GAP → SEND after `gap` cycles.
- DONE → IDLE unconditionally.
- `push` is combinational: `push` = (state==SEND) && (`occupancy` < `DEPTH`). A pop in the same cycle does not unblock a full FIFO.
- Occupancy update: `occupancy` ← `occupancy` + `push` − (`pop` && (`occupancy`≠0 || `push`)).
  - Pop on empty with no push is ignored.
  - Pop on empty with a simultaneous push cancels that push, matching the FIFO's push-then-pop ordering.
  - Occupancy tracks in every state, including IDLE and DONE.
- Data patterns; each advances only on a cycle with `push`=1:
  - Increment: starts at 0, +1 modulo 2^`D_WIDTH`.
  - LFSR: Galois, maximal-length taps per width; reloaded with `LFSR_SEED` at start and never 0.
  - Alternating: {01…} pattern, then its bitwise complement, repeating (for D_WIDTH=6: 6'h15, 6'h2A, 6'h15, …).
- `stall_cnt` increments on each SEND cycle with `push`=0, saturates at 16'hFFFF, and clears only on `rst` (not on start).
- `start` outside IDLE is ignored. `mode`, `length` and `gap` changes mid-transfer have no effect.

## Timing
- Reset values: state IDLE, `push` 0, `up_data` 0, `busy` 0, `done` 0, `occupancy` 0, `stall_cnt` 0, LFSR = `LFSR_SEED`, `sent` 0.
- `rst` mid-transfer aborts immediately with no `done` pulse and clears occupancy. The FIFO must be reset together with this block.
- `start` at cycle t: SEND at t+1, first `push` at t+1 if not full, with `up_data` = first pattern word.
- With `gap`=0 and no stalls, pushes occur on consecutive cycles t+1 … t+`length`. `done` fires at t+`length`+1, IDLE at t+`length`+2.
- With `gap`=g, pushes are spaced g+1 cycles apart.
- `up_data` is registered and holds its value while stalled.
- Earliest next accepted `start` is the cycle the FSM is back in IDLE (t+`length`+2 in the no-gap case).

## Structure
- Package `fifo_gen_pkg` holds:
  - state enum (IDLE/SEND/GAP/DONE);
  - mode enum;
  - alternating-pattern constant function of width;
  - LFSR tap table per width.
- Sub-module `lfsr_gen` (width, seed params; load, advance enables).
- Occupancy mirror, counters and FSM stay in the top module.

## Test plan
- Increment, `length`=3, `gap`=0, `pop` held 1 → pushes with `up_data` 0, 1, 2 on consecutive cycles. `done` one cycle after the last push; `occupancy` stays ≤1 and returns to 0.
- Increment, `length`=6, DEPTH=4, no pops → 4 pushes, then `push`=0 with `up_data`=4 held and `stall_cnt` counting. Two single pops → 2 more pushes, then `done`; `occupancy`=4.
- Alternating, `length`=4, `gap`=2 → `up_data` 15, 2A, 15, 2A, pushes 3 cycles apart.
- LFSR, `length`=63, pop every cycle → 63 distinct nonzero words, no word repeats; restart replays the identical sequence from `LFSR_SEED`.
- `length`=0 → `done` one cycle after `start`, no push. `start` while busy → ignored.
- `rst` asserted mid-SEND with `occupancy`=2 → next cycle all outputs at reset values and no `done`. Pop on empty with a simultaneous push → `occupancy` stays 0.
